fp_add_operand_stage: RTL

FP_ADD_OPERAND_STAGE -- requirements
Module: fp_add_operand_stage

---
 rtl/fp_add_operand_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fp_add_operand_stage.sv
// Operand-prep FIFO for an FP32 adder: orders each pair by magnitude, classifies both
// operands and precomputes exponent difference / effective-subtract at push time.
module fp_add_operand_stage #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_x,
  input  logic [31:0]              in_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_x,
  output logic [31:0]              out_y,
  output logic                     out_swapped,
  output logic [7:0]               out_exp_diff,
  output logic                     out_sub,
  output logic [2:0]               out_class_x,
  output logic [2:0]               out_class_y,
  output logic                     out_special,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] CLS_ZERO = 3'b000;
  localparam logic [2:0] CLS_SUB  = 3'b001;
  localparam logic [2:0] CLS_NORM = 3'b010;
  localparam logic [2:0] CLS_INF  = 3'b011;
  localparam logic [2:0] CLS_NAN  = 3'b100;

  function automatic logic [2:0] f_class(input logic [31:0] v);
    logic [2:0] c;
    if (v[30:23] == 8'h00)      c = (v[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
    else if (v[30:23] == 8'hFF) c = (v[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
    else                        c = CLS_NORM;
    return c;
  endfunction

  function automatic logic f_is_special(input logic [2:0] c);
    return (c == CLS_INF) || (c == CLS_NAN);
  endfunction

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [31:0] r_x_mem   [DEPTH];
  logic [31:0] r_y_mem   [DEPTH];
  logic        r_sw_mem  [DEPTH];
  logic [7:0]  r_ed_mem  [DEPTH];
  logic        r_sub_mem [DEPTH];
  logic [2:0]  r_cx_mem  [DEPTH];
  logic [2:0]  r_cy_mem  [DEPTH];
  logic        r_sp_mem  [DEPTH];

  logic        w_push;
  logic        w_pop;
  logic        w_swap;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic [2:0]  w_cls_big;
  logic [2:0]  w_cls_small;
  logic [7:0]  w_exp_diff;

  assign in_ready  = (r_count < FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  // Equal magnitudes keep the original order so X stays in front on ties.
  assign w_swap      = (in_y[30:0] > in_x[30:0]);
  assign w_big       = w_swap ? in_y : in_x;
  assign w_small     = w_swap ? in_x : in_y;
  assign w_cls_big   = f_class(w_big);
  assign w_cls_small = f_class(w_small);
  assign w_exp_diff  = w_big[30:23] - w_small[30:23];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Stored entries are cleared on reset so the head reads all-zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_x_mem[i]   <= '0;
        r_y_mem[i]   <= '0;
        r_sw_mem[i]  <= 1'b0;
        r_ed_mem[i]  <= '0;
        r_sub_mem[i] <= 1'b0;
        r_cx_mem[i]  <= '0;
        r_cy_mem[i]  <= '0;
        r_sp_mem[i]  <= 1'b0;
      end
    end else if (w_push) begin
      r_x_mem[r_wr_ptr]   <= w_big;
      r_y_mem[r_wr_ptr]   <= w_small;
      r_sw_mem[r_wr_ptr]  <= w_swap;
      r_ed_mem[r_wr_ptr]  <= w_exp_diff;
      r_sub_mem[r_wr_ptr] <= in_x[31] ^ in_y[31];
      r_cx_mem[r_wr_ptr]  <= w_cls_big;
      r_cy_mem[r_wr_ptr]  <= w_cls_small;
      r_sp_mem[r_wr_ptr]  <= f_is_special(w_cls_big) || f_is_special(w_cls_small);
    end
  end

  assign out_x        = r_x_mem[r_rd_ptr];
  assign out_y        = r_y_mem[r_rd_ptr];
  assign out_swapped  = r_sw_mem[r_rd_ptr];
  assign out_exp_diff = r_ed_mem[r_rd_ptr];
  assign out_sub      = r_sub_mem[r_rd_ptr];
  assign out_class_x  = r_cx_mem[r_rd_ptr];
  assign out_class_y  = r_cy_mem[r_rd_ptr];
  assign out_special  = r_sp_mem[r_rd_ptr];

endmodule
